// File: rtl/sa_pkg.sv
// Shared systolic-array definitions: partial-sum width, control encodings and signed saturation.
package sa_pkg;

  localparam int PSUM_MULT = 4;
  localparam int SAT_MAX_W = 64;

  typedef enum logic [1:0] {
    SA_CTRL_IDLE = 2'b00,
    SA_CTRL_LOAD = 2'b01,
    SA_CTRL_COMP = 2'b10
  } sa_ctrl_e;

  // Per-row control carried alongside the skewed data.
  typedef struct packed {
    logic valid;
    logic restart;
  } row_tag_t;

  typedef struct packed {
    logic                 clamped;
    logic [SAT_MAX_W-1:0] value;
  } sat_res_t;

  function automatic int psum_width(input int word_width);
    return PSUM_MULT * word_width;
  endfunction

  // Clamps a sign-extended value into the signed range of out_w bits.
  function automatic sat_res_t sat_signed(input logic signed [SAT_MAX_W-1:0] x,
                                          input int out_w);
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    sat_res_t r;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    r.clamped = 1'b0;
    r.value   = x;
    if (x > hi) begin
      r.value   = hi;
      r.clamped = 1'b1;
    end else if (x < lo) begin
      r.value   = lo;
      r.clamped = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sa_sync_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may coincide, including when full.
module sa_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: every variable gets its default before any condition, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only ever visible when the count says it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/sa_output_deskew.sv
// Realigns skewed systolic-array rows, narrows each element and buffers rows for writeback.
// Define SA_DESKEW_SAT_EN for signed saturation; otherwise elements wrap to their low bits.
module sa_output_deskew
  import sa_pkg::*;
#(
  parameter  int ARR_WIDTH  = 4,
  parameter  int WORD_WIDTH = 8,
  parameter  int OUT_WIDTH  = 16,
  parameter  int FIFO_DEPTH = 8,
  parameter  int ROW_W      = 16,
  localparam int PSUM_WIDTH = psum_width(WORD_WIDTH),
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PSUM_WIDTH*ARR_WIDTH-1:0] ps_in_vec,
  input  logic                          ps_in_valid,
  input  logic                          frame_start,
  output logic [OUT_WIDTH*ARR_WIDTH-1:0]  out_data,
  output logic [ROW_W-1:0]              out_row,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CNT_W-1:0]              fifo_count,
  output logic                          overflow,
  output logic                          sat_seen,
  input  logic                          err_clear
);

  localparam int LAT     = ARR_WIDTH - 1;
  localparam int DATA_W  = OUT_WIDTH * ARR_WIDTH;
  localparam int ENTRY_W = DATA_W + ROW_W;

  logic                                   frame_pend_q, frame_pend_d;
  row_tag_t                               tag_in, tag_al;
  logic [ARR_WIDTH-1:0][PSUM_WIDTH-1:0]   col_al;
  logic [ARR_WIDTH-1:0][OUT_WIDTH-1:0]    narrow;
  logic [ROW_W-1:0]                       row_cnt_q, row_cnt_d, row_idx;
  logic                                   overflow_q, overflow_d;
  logic                                   row_wr, pop, drop;
  logic                                   fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]                     head;

  // A lone frame_start is remembered until the next row enters the array output.
  assign tag_in.valid   = ps_in_valid;
  assign tag_in.restart = frame_start || frame_pend_q;

  if (LAT == 0) begin : g_tag_direct
    assign tag_al = tag_in;
  end else begin : g_tag_pipe
    row_tag_t tag_q [LAT];
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
      end else begin
        tag_q[0] <= tag_in;
        for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
      end
    end
    assign tag_al = tag_q[LAT-1];
  end

  // Column c waits ARR_WIDTH-1-c cycles; data needs no reset because the tag line qualifies it.
  for (genvar c = 0; c < ARR_WIDTH; c++) begin : g_col
    localparam int DLY = ARR_WIDTH - 1 - c;
    logic [PSUM_WIDTH-1:0] col_in;
    assign col_in = ps_in_vec[c*PSUM_WIDTH +: PSUM_WIDTH];
    if (DLY == 0) begin : g_direct
      assign col_al[c] = col_in;
    end else begin : g_pipe
      logic [PSUM_WIDTH-1:0] pipe_q [DLY];
      always_ff @(posedge clk) begin
        pipe_q[0] <= col_in;
        for (int i = 1; i < DLY; i++) pipe_q[i] <= pipe_q[i-1];
      end
      assign col_al[c] = pipe_q[DLY-1];
    end
  end

`ifdef SA_DESKEW_SAT_EN
  logic [ARR_WIDTH-1:0] clamp;
  logic                 sat_seen_q, sat_seen_d;

  for (genvar c = 0; c < ARR_WIDTH; c++) begin : g_narrow
    sat_res_t res;
    assign res       = sat_signed(SAT_MAX_W'(signed'(col_al[c])), OUT_WIDTH);
    assign narrow[c] = res.value[OUT_WIDTH-1:0];
    assign clamp[c]  = res.clamped;
    if (OUT_WIDTH < SAT_MAX_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^res.value[SAT_MAX_W-1:OUT_WIDTH];
    end
  end

  assign sat_seen_d = (sat_seen_q && !err_clear) || (row_wr && (|clamp));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sat_seen_q <= 1'b0;
    else       sat_seen_q <= sat_seen_d;
  end

  assign sat_seen = sat_seen_q;
`else
  for (genvar c = 0; c < ARR_WIDTH; c++) begin : g_narrow
    assign narrow[c] = col_al[c][OUT_WIDTH-1:0];
    if (OUT_WIDTH < PSUM_WIDTH) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^col_al[c][PSUM_WIDTH-1:OUT_WIDTH];
    end
  end

  assign sat_seen = 1'b0;
`endif

  // Rows are numbered at write time; dropped rows still consume an index.
  assign row_wr  = tag_al.valid;
  assign row_idx = tag_al.restart ? '0 : row_cnt_q;
  assign pop     = out_valid && out_ready;
  assign drop    = row_wr && fifo_full && !pop;

  always_comb begin
    row_cnt_d    = row_cnt_q;
    frame_pend_d = frame_pend_q;
    if (row_wr) row_cnt_d = row_idx + ROW_W'(1);
    if (ps_in_valid)      frame_pend_d = 1'b0;
    else if (frame_start) frame_pend_d = 1'b1;
    overflow_d = (overflow_q && !err_clear) || drop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_cnt_q    <= '0;
      frame_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      row_cnt_q    <= row_cnt_d;
      frame_pend_q <= frame_pend_d;
      overflow_q   <= overflow_d;
    end
  end

  sa_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (row_wr),
    .push_data_i ({row_idx, narrow}),
    .pop_i       (pop),
    .pop_data_o  (head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? head[DATA_W-1:0] : '0;
  assign out_row   = out_valid ? head[ENTRY_W-1:DATA_W] : '0;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sa_output_deskew.sv
// Self-checking bench for sa_output_deskew: directed scenarios plus a randomized phase,
// all compared every cycle against a row-level queue model of the collector.
module tb_sa_output_deskew;

  localparam int A    = 4;
  localparam int W    = 8;
  localparam int P    = 4 * W;
  localparam int O    = 16;
  localparam int D    = 8;
  localparam int RW   = 16;
  localparam int CW   = $clog2(D) + 1;
  localparam int MAXC = 1024;

  logic           clk = 1'b0;
  logic           reset;
  logic [P*A-1:0] ps_in_vec;
  logic           ps_in_valid;
  logic           frame_start;
  logic [O*A-1:0] out_data;
  logic [RW-1:0]  out_row;
  logic           out_valid;
  logic           out_ready;
  logic [CW-1:0]  fifo_count;
  logic           overflow;
  logic           sat_seen;
  logic           err_clear;

  always #5 clk = ~clk;

  sa_output_deskew #(
    .ARR_WIDTH  (A),
    .WORD_WIDTH (W),
    .OUT_WIDTH  (O),
    .FIFO_DEPTH (D),
    .ROW_W      (RW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps_in_vec   (ps_in_vec),
    .ps_in_valid (ps_in_valid),
    .frame_start (frame_start),
    .out_data    (out_data),
    .out_row     (out_row),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .sat_seen    (sat_seen),
    .err_clear   (err_clear)
  );

  typedef struct {
    logic [O*A-1:0] data;
    logic [RW-1:0]  row;
  } ent_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Rows as injected, indexed by the cycle their column 0 was presented.
  bit         inj_valid   [MAXC];
  bit         inj_restart [MAXC];
  logic [P-1:0] inj_cols  [MAXC][A];

  ent_t          m_q[$];
  logic [RW-1:0] m_cnt;
  bit            m_pend, m_ovf, m_sat;

  bit           cur_valid, cur_frame, cur_ready, cur_clear, cur_reset;
  logic [P-1:0] cur_cols [A];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [O-1:0] narrow(input logic [P-1:0] x, output bit clamped);
    longint     v, hi, lo;
    logic [63:0] r;
    v  = longint'(signed'(x));
    hi = (longint'(1) <<< (O - 1)) - 1;
    lo = -hi - 1;
    clamped = 1'b0;
`ifdef SA_DESKEW_SAT_EN
    if (v > hi) begin
      v = hi;
      clamped = 1'b1;
    end else if (v < lo) begin
      v = lo;
      clamped = 1'b1;
    end
`endif
    r = v;
    return r[O-1:0];
  endfunction

  function automatic logic [P-1:0] rand_col();
    case ($urandom_range(0, 2))
      0:       return P'($urandom_range(0, 30000));
      1:       return -P'($urandom_range(0, 30000));
      default: return P'($urandom);
    endcase
  endfunction

  task automatic compare();
    bit          v;
    logic [O*A-1:0] ed;
    logic [RW-1:0]  er;
    v  = (m_q.size() > 0);
    ed = '0;
    er = '0;
    if (v) begin
      ed = m_q[0].data;
      er = m_q[0].row;
    end
    check("out_valid", out_valid, v);
    check("out_data", out_data, ed);
    check("out_row", out_row, er);
    check("fifo_count", fifo_count, m_q.size());
    check("overflow", overflow, m_ovf);
    check("sat_seen", sat_seen, m_sat);
  endtask

  // Effects of one cycle's events, as seen by the consumer from the next cycle on.
  task automatic model_step();
    bit          pop, wr, acc, ov_ev, sat_ev, cl;
    int          k;
    ent_t        e;
    logic [RW-1:0] idx;
    pop    = (m_q.size() > 0) && cur_ready;
    k      = cyc - (A - 1);
    wr     = (k >= 0) && inj_valid[k];
    acc    = 1'b0;
    ov_ev  = 1'b0;
    sat_ev = 1'b0;
    if (wr) begin
      idx   = inj_restart[k] ? '0 : m_cnt;
      m_cnt = idx + 1'b1;
      for (int c = 0; c < A; c++) begin
        e.data[c*O +: O] = narrow(inj_cols[k][c], cl);
        sat_ev = sat_ev | cl;
      end
      e.row = idx;
      if (m_q.size() < D || pop) acc = 1'b1;
      else ov_ev = 1'b1;
    end
    m_ovf = (m_ovf && !cur_clear) || ov_ev;
    m_sat = (m_sat && !cur_clear) || sat_ev;
    if (pop) void'(m_q.pop_front());
    if (acc) m_q.push_back(e);
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, advance the model.
  task automatic run_cycle();
    logic [P*A-1:0] vec;
    int k;
    if (cur_reset) begin
      for (int i = 0; i <= cyc; i++) inj_valid[i] = 1'b0;
      m_q.delete();
      m_cnt  = '0;
      m_pend = 1'b0;
      m_ovf  = 1'b0;
      m_sat  = 1'b0;
    end else begin
      inj_valid[cyc] = cur_valid;
      if (cur_valid) begin
        inj_restart[cyc] = cur_frame || m_pend;
        for (int c = 0; c < A; c++) inj_cols[cyc][c] = cur_cols[c];
        m_pend = 1'b0;
      end else if (cur_frame) begin
        m_pend = 1'b1;
      end
    end
    for (int c = 0; c < A; c++) begin
      k = cyc - c;
      if (k >= 0 && inj_valid[k]) vec[c*P +: P] = inj_cols[k][c];
      else                        vec[c*P +: P] = P'($urandom);
    end
    reset       = cur_reset;
    ps_in_vec   = vec;
    ps_in_valid = cur_valid && !cur_reset;
    frame_start = cur_frame && !cur_reset;
    out_ready   = cur_ready;
    err_clear   = cur_clear;
    @(negedge clk);
    compare();
    if (!cur_reset) model_step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= MAXC - 1) begin
      $display("FAIL cycle_budget cycle=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic idle(input int n);
    cur_valid = 1'b0;
    cur_frame = 1'b0;
    repeat (n) run_cycle();
  endtask

  task automatic send_row(input bit fs);
    cur_valid = 1'b1;
    cur_frame = fs;
    run_cycle();
    cur_valid = 1'b0;
    cur_frame = 1'b0;
  endtask

  task automatic rand_cols();
    for (int c = 0; c < A; c++) cur_cols[c] = rand_col();
  endtask

  initial begin
    logic [15:0] exp0, exp1;
    bit          exp_sat;

    cur_valid = 1'b0; cur_frame = 1'b0; cur_ready = 1'b0;
    cur_clear = 1'b0; cur_reset = 1'b1;
    rand_cols();
    reset = 1'b1; ps_in_valid = 1'b0; frame_start = 1'b0;
    out_ready = 1'b0; err_clear = 1'b0; ps_in_vec = '0;
    #1;

    // Reset state.
    idle(2);
    check("reset_valid", out_valid, 1'b0);
    check("reset_count", fifo_count, 0);
    check("reset_data", out_data, 0);
    cur_reset = 1'b0;
    cur_ready = 1'b1;
    idle(2);

    // Single row: visible exactly ARR_WIDTH cycles after column 0.
    for (int c = 0; c < A; c++) cur_cols[c] = P'(10 * (c + 1));
    send_row(1'b1);
    idle(2);
    check("single_early", out_valid, 1'b0);
    idle(1);
    check("single_valid", out_valid, 1'b1);
    check("single_data", out_data, 64'h0028_001E_0014_000A);
    check("single_row", out_row, 0);
    idle(1);
    check("single_gone", out_valid, 1'b0);

    // Four back-to-back rows with frame restart on the first.
    for (int i = 0; i < 4; i++) begin
      rand_cols();
      send_row(i == 0);
    end
    for (int i = 0; i < 4; i++) begin
      check("b2b_valid", out_valid, 1'b1);
      check("b2b_row", out_row, i);
      idle(1);
    end
    check("b2b_gone", out_valid, 1'b0);

    // Overflow: nine rows with the consumer stalled.
    cur_clear = 1'b1;
    idle(1);
    cur_clear = 1'b0;
    cur_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rand_cols();
      send_row(i == 0);
    end
    idle(4);
    check("ovf_count", fifo_count, D);
    check("ovf_flag", overflow, 1'b1);
    cur_ready = 1'b1;
    for (int i = 0; i < D; i++) begin
      check("drain_row", out_row, i);
      idle(1);
    end
    check("drain_empty", out_valid, 1'b0);
    cur_clear = 1'b1;
    idle(1);
    cur_clear = 1'b0;
    check("ovf_cleared", overflow, 1'b0);

    // Full FIFO with write and pop in the same cycle.
    cur_ready = 1'b0;
    for (int i = 0; i < D; i++) begin
      rand_cols();
      send_row(1'b0);
    end
    idle(3);
    check("full_count", fifo_count, D);
    rand_cols();
    send_row(1'b0);
    idle(2);
    cur_ready = 1'b1;
    idle(1);
    cur_ready = 1'b0;
    check("wrpop_count", fifo_count, D);
    check("wrpop_ovf", overflow, 1'b0);
    cur_ready = 1'b1;
    idle(D + 2);

    // Narrowing of out-of-range elements.
    cur_clear = 1'b1;
    idle(1);
    cur_clear = 1'b0;
    cur_cols[0] = P'(40000);
    cur_cols[1] = -P'(40000);
    cur_cols[2] = '0;
    cur_cols[3] = P'(123);
`ifdef SA_DESKEW_SAT_EN
    exp0 = 16'h7FFF; exp1 = 16'h8000; exp_sat = 1'b1;
`else
    exp0 = 16'h9C40; exp1 = 16'h63C0; exp_sat = 1'b0;
`endif
    send_row(1'b0);
    idle(3);
    check("narrow_valid", out_valid, 1'b1);
    check("narrow_pos", out_data[15:0], exp0);
    check("narrow_neg", out_data[31:16], exp1);
    idle(1);
    check("narrow_sat", sat_seen, exp_sat);

    // Reset with rows buffered and rows still in the delay line.
    cur_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_cols();
      send_row(1'b0);
    end
    idle(3);
    check("pre_rst_count", fifo_count, 3);
    for (int i = 0; i < 2; i++) begin
      rand_cols();
      send_row(1'b0);
    end
    cur_reset = 1'b1;
    idle(1);
    check("rst_valid", out_valid, 1'b0);
    check("rst_count", fifo_count, 0);
    check("rst_data", out_data, 0);
    check("rst_row", out_row, 0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_sat", sat_seen, 1'b0);
    cur_reset = 1'b0;
    cur_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check("post_rst_quiet", out_valid, 1'b0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      rand_cols();
      cur_valid = ($urandom_range(0, 3) != 0);
      cur_frame = ($urandom_range(0, 19) == 0);
      cur_ready = ($urandom_range(0, 2) != 0);
      cur_clear = ($urandom_range(0, 15) == 0);
      cur_reset = ($urandom_range(0, 149) == 0);
      run_cycle();
    end
    cur_reset = 1'b0;
    cur_clear = 1'b0;
    cur_ready = 1'b1;
    idle(D + A + 4);
    check("final_empty", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
